// File: rtl/p4_router_trtcm_policer.sv
// ============================================================================
// p4_router_trtcm_policer : per-port colour-blind trTCM policer on AXIS
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module p4_router_trtcm_policer #(
  parameter int NUM_PORTS     = 8,
  parameter int DATA_BYTES    = 8,
  parameter int USER_WIDTH    = 32,
  parameter int PORT_LSB      = 0,
  parameter int BUCKET_WIDTH  = 24,
  parameter int RATE_WIDTH    = 16,
  parameter int REFILL_PERIOD = 64,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic                              s_axis_tvalid_i,
  output logic                              s_axis_tready_o,
  input  logic [DATA_BYTES*8-1:0]           s_axis_tdata_i,
  input  logic [DATA_BYTES-1:0]             s_axis_tkeep_i,
  input  logic                              s_axis_tlast_i,
  input  logic [USER_WIDTH-1:0]             s_axis_tuser_i,
  output logic                              m_axis_tvalid_o,
  input  logic                              m_axis_tready_i,
  output logic [DATA_BYTES*8-1:0]           m_axis_tdata_o,
  output logic [DATA_BYTES-1:0]             m_axis_tkeep_o,
  output logic                              m_axis_tlast_o,
  output logic [USER_WIDTH+1:0]             m_axis_tuser_o,
  input  logic [2*NUM_PORTS-1:0]            port_mode_i,
  input  logic [RATE_WIDTH*NUM_PORTS-1:0]   cir_inc_i,
  input  logic [RATE_WIDTH*NUM_PORTS-1:0]   pir_inc_i,
  input  logic [BUCKET_WIDTH*NUM_PORTS-1:0] cbs_i,
  input  logic [BUCKET_WIDTH*NUM_PORTS-1:0] pbs_i,
  output logic [CNT_WIDTH*NUM_PORTS-1:0]    drop_cnt_o,
  input  logic [NUM_PORTS-1:0]              drop_cnt_clear_i
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int RW = (REFILL_PERIOD > 2) ? $clog2(REFILL_PERIOD) : 1;
  localparam int BW = BUCKET_WIDTH;
  localparam logic [1:0] c_green  = 2'd0;
  localparam logic [1:0] c_yellow = 2'd1;
  localparam logic [1:0] c_red    = 2'd2;

  function automatic logic [BW-1:0] sat_sub(input logic [BW-1:0] b, input logic [15:0] n);
    logic [BW+15:0] bb;
    logic [BW+15:0] nn;
    bb = (BW+16)'(b);
    nn = (BW+16)'(n);
    return (bb > nn) ? BW'(bb - nn) : '0;
  endfunction

  function automatic logic [BW-1:0] add_clamp(input logic [BW-1:0] b,
                                              input logic [RATE_WIDTH-1:0] inc,
                                              input logic [BW-1:0] ceil);
    logic [BW:0] s;
    s = {1'b0, b} + (BW+1)'(inc);
    return (s > {1'b0, ceil}) ? ceil : s[BW-1:0];
  endfunction

  logic                   sof_q;
  logic [PW-1:0]          port_q;
  logic [1:0]             col_q;
  logic                   drop_q, act_q;
  logic [15:0]            bytes_q;
  logic [RW-1:0]          rcnt_q;
  logic [BW-1:0]          cbkt_q [NUM_PORTS];
  logic [BW-1:0]          pbkt_q [NUM_PORTS];
  logic [BW-1:0]          cbkt_d [NUM_PORTS];
  logic [BW-1:0]          pbkt_d [NUM_PORTS];
  logic [CNT_WIDTH-1:0]   dcnt_q [NUM_PORTS];
  logic [CNT_WIDTH-1:0]   dcnt_d [NUM_PORTS];
  logic                   mvalid_q, mlast_q;
  logic [DATA_BYTES*8-1:0] mdata_q;
  logic [DATA_BYTES-1:0]  mkeep_q;
  logic [USER_WIDTH+1:0]  muser_q;

  logic          w_sready, w_acc, w_sof_inr, w_sof_drop, w_sof_act, w_wrap, w_debit;
  logic [PW-1:0] w_sof_port, w_port;
  logic [1:0]    w_sof_mode, w_sof_col, w_col;
  logic          w_drop, w_act;
  logic [15:0]   w_beat, w_total;
  logic [16:0]   w_sum;

  assign w_sready   = !mvalid_q || m_axis_tready_i;
  assign w_acc      = s_axis_tvalid_i && w_sready;
  assign w_sof_port = s_axis_tuser_i[PORT_LSB +: PW];

  generate
    if (NUM_PORTS == (1 << PW)) begin : g_inr_full
      assign w_sof_inr = 1'b1;
    end else begin : g_inr_part
      assign w_sof_inr = ({1'b0, w_sof_port} < (PW+1)'(NUM_PORTS));
    end
  endgenerate

  assign w_sof_mode = w_sof_inr ? port_mode_i[{w_sof_port, 1'b0} +: 2] : 2'd0;

  // Colour-blind decision: peak bucket empty dominates committed bucket empty.
  always_comb begin
    w_sof_col = c_green;
    if (w_sof_mode != 2'd0) begin
      if (pbkt_q[w_sof_port] == '0)      w_sof_col = c_red;
      else if (cbkt_q[w_sof_port] == '0) w_sof_col = c_yellow;
    end
  end

  assign w_sof_drop = w_sof_mode[1] && (w_sof_col == c_red);
  assign w_sof_act  = (w_sof_mode != 2'd0);

  assign w_port = sof_q ? w_sof_port : port_q;
  assign w_col  = sof_q ? w_sof_col  : col_q;
  assign w_drop = sof_q ? w_sof_drop : drop_q;
  assign w_act  = sof_q ? w_sof_act  : act_q;

  always_comb begin
    w_beat = '0;
    for (int b = 0; b < DATA_BYTES; b++) w_beat = w_beat + 16'(s_axis_tkeep_i[b]);
  end

  assign w_sum   = {1'b0, (sof_q ? 16'd0 : bytes_q)} + {1'b0, w_beat};
  assign w_total = w_sum[16] ? 16'hFFFF : w_sum[15:0];
  assign w_debit = w_acc && s_axis_tlast_i && w_act;
  assign w_wrap  = (rcnt_q == RW'(REFILL_PERIOD - 1));

  // Debit is applied before the refill add so a same-cycle wrap sees the floored value.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cbkt_d[i] = cbkt_q[i];
      pbkt_d[i] = pbkt_q[i];
      if (w_debit && (w_port == PW'(i))) begin
        if (w_col == c_green) cbkt_d[i] = sat_sub(cbkt_q[i], w_total);
        if (w_col != c_red)   pbkt_d[i] = sat_sub(pbkt_q[i], w_total);
      end
      if (w_wrap) begin
        cbkt_d[i] = add_clamp(cbkt_d[i], cir_inc_i[i*RATE_WIDTH +: RATE_WIDTH], cbs_i[i*BW +: BW]);
        pbkt_d[i] = add_clamp(pbkt_d[i], pir_inc_i[i*RATE_WIDTH +: RATE_WIDTH], pbs_i[i*BW +: BW]);
      end
      dcnt_d[i] = dcnt_q[i];
      if (w_acc && sof_q && w_sof_drop && (w_sof_port == PW'(i)) && (dcnt_q[i] != '1))
        dcnt_d[i] = dcnt_q[i] + 1'b1;
      if (drop_cnt_clear_i[i]) dcnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sof_q    <= 1'b1;
      port_q   <= '0;
      col_q    <= c_green;
      drop_q   <= 1'b0;
      act_q    <= 1'b0;
      bytes_q  <= '0;
      rcnt_q   <= '0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      mkeep_q  <= '0;
      mlast_q  <= 1'b0;
      muser_q  <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cbkt_q[i] <= '0;
        pbkt_q[i] <= '0;
        dcnt_q[i] <= '0;
      end
    end else begin
      rcnt_q <= w_wrap ? '0 : rcnt_q + 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cbkt_q[i] <= cbkt_d[i];
        pbkt_q[i] <= pbkt_d[i];
        dcnt_q[i] <= dcnt_d[i];
      end
      if (w_acc) begin
        sof_q   <= s_axis_tlast_i;
        bytes_q <= s_axis_tlast_i ? 16'd0 : w_total;
        if (sof_q) begin
          port_q <= w_sof_port;
          col_q  <= w_sof_col;
          drop_q <= w_sof_drop;
          act_q  <= w_sof_act;
        end
      end
      if (w_sready) begin
        mvalid_q <= w_acc && !w_drop;
        if (w_acc && !w_drop) begin
          mdata_q <= s_axis_tdata_i;
          mkeep_q <= s_axis_tkeep_i;
          mlast_q <= s_axis_tlast_i;
          muser_q <= {w_col, s_axis_tuser_i};
        end
      end
    end
  end

  assign s_axis_tready_o = w_sready;
  assign m_axis_tvalid_o = mvalid_q;
  assign m_axis_tdata_o  = mdata_q;
  assign m_axis_tkeep_o  = mkeep_q;
  assign m_axis_tlast_o  = mlast_q;
  assign m_axis_tuser_o  = muser_q;

  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
      assign drop_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = dcnt_q[g];
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/p4_router_trtcm_policer.md
# p4_router_trtcm_policer

- Per-port two-rate three-colour policer (trTCM, colour-blind) on the classified-packet AXIS bus, between classification and the queue system.
- Keeps a committed and a peak byte bucket per ingress port and colours each packet green, yellow or red at its first beat.
- Per port, it can pass the colour through, mark it, or drop red packets.
- Successor to the single-threshold ingress policer: adds dual rates, a colour output and a drop counter.

## Interface
- NUM_PORTS, 8: ingress ports policed; port index width PW = $clog2(NUM_PORTS), minimum 1.
- DATA_BYTES, 8: AXIS data bytes per beat.
- USER_WIDTH, 32: input tuser width; output tuser is USER_WIDTH+2.
- PORT_LSB, 0: LSB of the port index field in input tuser.
- BUCKET_WIDTH, 24: bucket and burst width, in bytes.
- RATE_WIDTH, 16: per-refill increment width, in bytes.
- REFILL_PERIOD, 64: cycles between refills; must be ≥2.
- CNT_WIDTH, 32: drop counter width.
- clk  in  1  sole clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis  AXIS slave  DATA_BYTES/USER_WIDTH  classified packets; uses tvalid, tready, tdata, tkeep, tlast, tuser.
- m_axis  AXIS master  DATA_BYTES/USER_WIDTH+2  policed packets; tuser = {colour[1:0], input tuser}.
- port_mode  in  2*NUM_PORTS  per-port mode: 0 bypass, 1 mark, 2 drop-red, 3 same as 2.
- cir_inc, pir_inc  in  RATE_WIDTH*NUM_PORTS  committed/peak bytes added per refill.
- cbs, pbs  in  BUCKET_WIDTH*NUM_PORTS  committed/peak burst, the bucket ceilings.
- drop_cnt  out  CNT_WIDTH*NUM_PORTS  red packets dropped per port; saturating.
- drop_cnt_clear  in  NUM_PORTS  per-port synchronous clear of drop_cnt.

## Operation
- Colour encoding: 0 green, 1 yellow, 2 red.
- Port index p = s_axis.tuser[PORT_LSB +: PW], sampled on the SOF beat only and latched for the packet.
- SOF is the first accepted beat after reset or after a tlast beat.
- Colour at SOF:
  - mode 0, or p ≥ NUM_PORTS: green, no debit.
  - Otherwise red if P[p]==0, else yellow if C[p]==0, else green.
- Byte count per packet: sum of popcount(tkeep) over accepted beats, 16-bit saturating.
- Debit on the tlast beat, applied only for ports in mode ≠ 0:
  - green: C and P each decremented by the byte count, floored at 0.
  - yellow: P only.
  - red: none.
- Refill: a free-running counter wraps at REFILL_PERIOD-1. On the wrap cycle, every port does C=min(C+cir_inc, cbs) and P=min(P+pir_inc, pbs), using BUCKET_WIDTH+1-bit intermediates.
- Refill and debit in the same cycle on the same port: debit first, floor at 0, then add and clamp.
- cbs/pbs lowered below the current bucket value: the bucket is clamped at the next refill, not before.
- Mode 2 with a red packet:
  - All beats are accepted (s_axis.tready follows the pipeline rule) and none is presented on m_axis.
  - drop_cnt[p] increments once, on the SOF beat.
- drop_cnt_clear in the same cycle as an increment: clear wins, result 0.
- Mode 1 or 0: every beat is forwarded, and colour is placed in the output tuser on every beat of the packet.
- Mode changes take effect at the next SOF. A packet in flight keeps its latched colour and drop decision.

## Timing
- One registered stage: s_axis.tready = !m_axis.tvalid || m_axis.tready.
- Latency from accepted input beat to m_axis.tvalid is one cycle; full throughput, no bubbles.
- Dropped beats are accepted at s_axis.tready and produce no output.
- Bucket updates from a tlast beat accepted in cycle N are visible to an SOF accepted in cycle N+1.
- Reset values:
  - all buckets 0 (packets red until refilled).
  - m_axis.tvalid 0; m_axis tdata/tkeep/tuser/tlast 0.
  - drop_cnt 0; refill counter 0.
  - SOF flag set; byte count 0.
- Reset asserted mid-packet: the output beat is lost, and the next accepted beat is treated as SOF.
- m_axis held stable while tvalid && !tready.

## Test plan
- Refill: cir_inc=100, pir_inc=200, cbs=1000, pbs=3000, REFILL_PERIOD=64, no traffic, 20 refills -> C=1000, P=3000, each clamped at its burst.
- Colour sequence: port 3 in mode 1, C=1000, P=3000, no refill during the test, three 1000-byte packets back-to-back.
  - -> colours green, yellow, yellow, then a fourth packet red.
  - -> final C=0, P=0.
- Drop: port 2 in mode 2 with P=0, 4 packets of 64 bytes each -> no m_axis beats, drop_cnt[2]=4, s_axis.tready never low.
- Backpressure: m_axis.tready toggled 1010 under a continuous stream -> output data identical to input, order preserved, payload stable while stalled.
- Same-cycle debit and refill: C=50, cir_inc=100, cbs=120, a 80-byte green tlast on the wrap cycle -> C = min(max(50-80, 0) + 100, 120) = 100.
- Counter corners:
  - CNT_WIDTH=4 with 20 red drops -> drop_cnt saturates at 15.
  - Clear coincident with a drop -> drop_cnt = 0.
  - p ≥ NUM_PORTS -> green, no debit.
